key_matrix_scan: RTL

KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

---
 rtl/key_scan_pkg.sv | 42 ++++
 rtl/key_row_sync.sv | 33 +++
 rtl/key_matrix_scan.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - shared types and constants for the key matrix scanner
//
// Purpose : FSM state enum, frame-class enum, column strobe constants and
//           key code width used by key_matrix_scan and key_row_sync.
// Ports   : none (package).
package key_scan_pkg;

   localparam int KEY_W = 4;   // key code = {col_idx[1:0], row_idx[1:0]}
   localparam int ROW_W = 4;   // row sense lines
   localparam int COL_W = 4;   // column strobes

   // Active-low one-hot column strobes, indexed by column number.
   localparam logic [COL_W-1:0] COL_STROBE_0 = 4'b1110;
   localparam logic [COL_W-1:0] COL_STROBE_1 = 4'b1101;
   localparam logic [COL_W-1:0] COL_STROBE_2 = 4'b1011;
   localparam logic [COL_W-1:0] COL_STROBE_3 = 4'b0111;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } scan_state_e;

   typedef enum logic [1:0] {
      FRAME_NONE   = 2'd0,
      FRAME_SINGLE = 2'd1,
      FRAME_MULTI  = 2'd2
   } frame_class_e;

   function automatic logic [COL_W-1:0] col_strobe(input logic [1:0] idx);
      logic [COL_W-1:0] s;
      case (idx)
         2'd0:    s = COL_STROBE_0;
         2'd1:    s = COL_STROBE_1;
         2'd2:    s = COL_STROBE_2;
         default: s = COL_STROBE_3;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/key_row_sync.sv
// rtl/key_row_sync.sv - two-flop synchronizer for the asynchronous row lines
//
// Purpose : bring the pulled-up, active-low row sense lines into the clk_i
//           domain. Reset value is all ones (no key pressed).
// Ports   : clk_i   - clock
//           rst_ni  - asynchronous active-low reset
//           row_i   - raw row lines (asynchronous)
//           row_o   - synchronized row lines
module key_row_sync
   import key_scan_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [ROW_W-1:0] row_i,
   output logic [ROW_W-1:0] row_o
);

   logic [ROW_W-1:0] meta_q;
   logic [ROW_W-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= row_i;
         sync_q <= meta_q;
      end
   end

   assign row_o = sync_q;

endmodule

// File: rtl/key_matrix_scan.sv
// rtl/key_matrix_scan.sv - 4x4 key matrix scanner with debounce
//
// Purpose : strobes the columns, samples the rows into a 16-bit frame image,
//           classifies each complete frame and debounces a single key press
//           and its release.
// Config  : KEY_REPEAT_EN - when defined, key_valid re-pulses every
//           REPEAT_FRAMES frames while a key stays in PRESSED.
// Ports   : CLK       - clock
//           reset_n   - asynchronous active-low reset
//           row       - row sense lines, active-low, asynchronous
//           col       - column strobe, active-low one-hot
//           key       - last accepted key code {col_idx, row_idx}
//           key_valid - one-cycle pulse on acceptance (and on repeat)
//           key_held  - high while the accepted key is held down
module key_matrix_scan
   import key_scan_pkg::*;
#(
   parameter int SCAN_DIV      = 256,
   parameter int DEBOUNCE      = 4,
   parameter int REPEAT_FRAMES = 64
) (
   input  logic             CLK,
   input  logic             reset_n,
   input  logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic [KEY_W-1:0] key,
   output logic             key_valid,
   output logic             key_held
);

   if (SCAN_DIV < 4) begin : g_bad_scan_div
      $error("key_matrix_scan: SCAN_DIV must be at least 4");
   end
   if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
      $error("key_matrix_scan: DEBOUNCE must be in 1..15");
   end
   if (REPEAT_FRAMES < 1) begin : g_bad_repeat
      $error("key_matrix_scan: REPEAT_FRAMES must be at least 1");
   end

   localparam int                  PRESC_W    = $clog2(SCAN_DIV);
   localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
   localparam logic [3:0]          DEB_CNT    = 4'(DEBOUNCE);

   // ------------------------------------------------------------------
   // Row synchronizer
   // ------------------------------------------------------------------
   logic [ROW_W-1:0] row_sync;

   key_row_sync u_row_sync (
      .clk_i  (CLK),
      .rst_ni (reset_n),
      .row_i  (row),
      .row_o  (row_sync)
   );

   // ------------------------------------------------------------------
   // Prescaler, column walk and frame image
   // ------------------------------------------------------------------
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [1:0]         col_idx_q, col_idx_d;
   logic [15:0]        image_q, image_d;
   logic [15:0]        frame_image;
   logic               tick;
   logic               frame_end;

   assign tick      = (presc_q == PRESC_LAST);
   assign frame_end = tick && (col_idx_q == 2'd3);
   assign col       = col_strobe(col_idx_q);

   // The image as it will look after this tick's sample; at frame end this
   // is the complete frame, so classification does not wait a cycle.
   always_comb begin
      frame_image = image_q;
      frame_image[{col_idx_q, 2'b00} +: ROW_W] = row_sync;
   end

   always_comb begin
      presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
      col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;
      image_d   = tick ? frame_image : image_q;
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         presc_q   <= '0;
         col_idx_q <= 2'd0;
         image_q   <= '1;
      end else begin
         presc_q   <= presc_d;
         col_idx_q <= col_idx_d;
         image_q   <= image_d;
      end
   end

   // ------------------------------------------------------------------
   // Frame classifier
   // ------------------------------------------------------------------
   logic [4:0]       low_count;
   logic [KEY_W-1:0] low_code;
   frame_class_e     frame_class;

   // Image bit index equals the key code, so the position of the single
   // low bit is the candidate code directly.
   always_comb begin
      low_count = '0;
      low_code  = '0;
      for (int i = 0; i < 16; i++) begin
         if (!frame_image[i]) begin
            low_count = low_count + 5'd1;
            low_code  = KEY_W'(i);
         end
      end
      if (low_count == 5'd0) begin
         frame_class = FRAME_NONE;
      end else if (low_count == 5'd1) begin
         frame_class = FRAME_SINGLE;
      end else begin
         frame_class = FRAME_MULTI;
      end
   end

   // ------------------------------------------------------------------
   // Debounce FSM
   // ------------------------------------------------------------------
   scan_state_e      state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       cnt_inc;
   logic [KEY_W-1:0] cand_q, cand_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             key_valid_q, key_valid_d;
   logic             key_held_q, key_held_d;
   logic             accept;
   logic             repeat_fire;

   assign cnt_inc = cnt_q + 4'd1;

   // State register
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         cand_q      <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   // Next-state logic; evaluates only at frame end.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      accept  = 1'b0;
      if (frame_end) begin
         unique case (state_q)
            ST_IDLE: begin
               if (frame_class == FRAME_SINGLE) begin
                  cand_d = low_code;
                  cnt_d  = 4'd1;
                  if (DEBOUNCE == 1) begin
                     state_d = ST_PRESSED;
                     accept  = 1'b1;
                  end else begin
                     state_d = ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (frame_class == FRAME_SINGLE && low_code == cand_q) begin
                  if (cnt_inc == DEB_CNT) begin
                     state_d = ST_PRESSED;
                     cnt_d   = 4'd0;
                     accept  = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = 4'd0;
               end
            end
            ST_PRESSED: begin
               // Any activity, including a second key, keeps the held key.
               if (frame_class == FRAME_NONE) begin
                  cnt_d   = 4'd1;
                  state_d = (DEBOUNCE == 1) ? ST_IDLE : ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (frame_class == FRAME_NONE) begin
                  if (cnt_inc == DEB_CNT) begin
                     state_d = ST_IDLE;
                     cnt_d   = 4'd0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = ST_PRESSED;
                  cnt_d   = 4'd0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

`ifdef KEY_REPEAT_EN
   // Repeat counter: frames spent in PRESSED since the last pulse or since
   // (re-)entry; any frame that does not stay in PRESSED restarts it.
   localparam int               REP_W    = $clog2(REPEAT_FRAMES + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);

   logic [REP_W-1:0] rep_q, rep_d;

   always_comb begin
      rep_d       = rep_q;
      repeat_fire = 1'b0;
      if (frame_end) begin
         if (state_q == ST_PRESSED && state_d == ST_PRESSED) begin
            if (rep_q == REP_LAST) begin
               rep_d       = '0;
               repeat_fire = 1'b1;
            end else begin
               rep_d = rep_q + REP_W'(1);
            end
         end else begin
            rep_d = '0;
         end
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end
`else
   assign repeat_fire = 1'b0;
`endif

   // Output logic
   always_comb begin
      key_d       = key_q;
      key_valid_d = accept | repeat_fire;
      key_held_d  = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
      if (accept) begin
         key_d = cand_d;
      end
   end

   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule
